// File: rtl/adder_cla.sv
// adder_cla: two-level carry-lookahead adder.
// Bits are grouped into BW_GRP-wide lookahead groups. Each group produces a
// group propagate/generate pair, and a second-level lookahead unit turns those
// into every group's carry-in directly from i_c, so no carry ripples between
// groups. A registered copy of the result is provided with one cycle of latency.
module adder_cla #(
  parameter int BW_DATA = 32,  // operand/sum width, multiple of BW_GRP, 4..64
  parameter int BW_GRP  = 4    // bits per lookahead group
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_c,
  output logic [BW_DATA-1:0] o_s,
  output logic               o_c,
  output logic [BW_DATA-1:0] o_s_q,
  output logic               o_c_q
);

  localparam int N_GRP = BW_DATA / BW_GRP;

  // Group-level propagate/generate and the group carries (w_cg[0] is i_c).
  logic [N_GRP-1:0] w_pg;
  logic [N_GRP-1:0] w_gg;
  logic [N_GRP:0]   w_cg;

  // Registered result.
  logic [BW_DATA-1:0] r_s_q;
  logic               r_c_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_GRP; gi++) begin : g_grp
      logic [BW_GRP-1:0] w_p;
      logic [BW_GRP-1:0] w_g;
      logic [BW_GRP:0]   w_cc;
      logic              w_gg_loc;

      assign w_p = i_a[gi*BW_GRP +: BW_GRP] ^ i_b[gi*BW_GRP +: BW_GRP];
      assign w_g = i_a[gi*BW_GRP +: BW_GRP] & i_b[gi*BW_GRP +: BW_GRP];

      // In-group carries in fully expanded sum-of-products form:
      // c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]cin, each term built directly
      // from the group carry-in rather than from the previous bit's carry.
      always_comb begin
        logic acc;
        logic term;
        w_cc    = '0;
        w_cc[0] = w_cg[gi];
        for (int k = 0; k < BW_GRP; k++) begin
          acc = 1'b0;
          for (int j = 0; j <= k + 1; j++) begin
            // j == 0 selects the carry-in term, j > 0 selects generate g[j-1]
            term = (j == 0) ? w_cg[gi] : w_g[j-1];
            for (int m = 0; m < BW_GRP; m++) begin
              if (m >= j && m <= k) begin
                term = term & w_p[m];
              end
            end
            acc = acc | term;
          end
          w_cc[k+1] = acc;
        end
      end

      // Group generate: the expanded carry-out of the group with the carry-in
      // term left out, so it is independent of the group's carry-in.
      always_comb begin
        logic term;
        w_gg_loc = 1'b0;
        for (int j = 0; j < BW_GRP; j++) begin
          term = w_g[j];
          for (int m = 0; m < BW_GRP; m++) begin
            if (m > j) begin
              term = term & w_p[m];
            end
          end
          w_gg_loc = w_gg_loc | term;
        end
      end

      assign w_pg[gi] = &w_p;
      assign w_gg[gi] = w_gg_loc;
      assign o_s[gi*BW_GRP +: BW_GRP] = w_p ^ w_cc[BW_GRP-1:0];
    end
  endgenerate

  // Second-level lookahead: every group carry expanded straight from i_c,
  // C[j+1] = GG[j] | PG[j]GG[j-1] | ... | PG[j..0]i_c.
  always_comb begin
    logic acc;
    logic term;
    w_cg    = '0;
    w_cg[0] = i_c;
    for (int k = 0; k < N_GRP; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k + 1; j++) begin
        term = (j == 0) ? i_c : w_gg[j-1];
        for (int m = 0; m < N_GRP; m++) begin
          if (m >= j && m <= k) begin
            term = term & w_pg[m];
          end
        end
        acc = acc | term;
      end
      w_cg[k+1] = acc;
    end
  end

  assign o_c = w_cg[N_GRP];

  // Capture the combinational result each edge; reset clears it and wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_q <= '0;
      r_c_q <= 1'b0;
    end else begin
      r_s_q <= o_s;
      r_c_q <= o_c;
    end
  end

  assign o_s_q = r_s_q;
  assign o_c_q = r_c_q;

endmodule

// File: tb/tb_adder_cla.sv
// Self-checking bench for adder_cla: directed corner cases plus a randomized
// regression compared with a plain-arithmetic a+b+c reference model.
module tb_adder_cla;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        c;
  logic [31:0] s;
  logic        co;
  logic [31:0] s_q;
  logic        co_q;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_cla #(.BW_DATA(32), .BW_GRP(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_a   (a),
    .i_b   (b),
    .i_c   (c),
    .o_s   (s),
    .o_c   (co),
    .o_s_q (s_q),
    .o_c_q (co_q)
  );

  // Reference: full-precision unsigned addition.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'b0, ci};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed={c,s}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a vector away from the rising edge and check the combinational sum 1 ns later.
  task automatic drive(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic [32:0] exp);
    @(negedge clk);
    a = x;
    b = y;
    c = ci;
    #1;
    $display("vec %s a=%h b=%h c=%0d -> s=%h co=%0d", tag, x, y, ci, s, co);
    chk({tag, "_comb"}, {co, s}, exp);
  endtask

  // Check the registered outputs just after the next rising edge.
  task automatic chk_reg(input string tag, input logic [32:0] exp);
    @(posedge clk);
    #1;
    chk({tag, "_reg"}, {co_q, s_q}, exp);
  endtask

  logic [31:0] rx;
  logic [31:0] ry;
  logic        rc;
  logic [32:0] rexp;

  initial begin
    rst = 1'b1;
    a   = 32'd0;
    b   = 32'd0;
    c   = 1'b0;

    // Reset held for two edges: registers cleared, combinational path unaffected.
    drive("rst", 32'd5, 32'd7, 1'b0, 33'd12);
    chk_reg("rst1", 33'd0);
    chk("rst1_comb", {co, s}, 33'd12);
    chk_reg("rst2", 33'd0);
    chk("rst2_comb", {co, s}, 33'd12);
    @(negedge clk);
    rst = 1'b0;
    chk_reg("post_rst", 33'd12);

    // Carry propagated through every group.
    drive("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
    chk_reg("ripple", 33'h1_0000_0000);

    // Largest possible sum.
    drive("maxsum", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    chk_reg("maxsum", 33'h1_FFFF_FFFF);

    // Carry crossing a group boundary and into the top bit.
    drive("grp_bnd", 32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010);
    chk_reg("grp_bnd", 33'h0_0000_0010);
    drive("msb", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
    chk_reg("msb", 33'h0_8000_0000);

    // Zero and a mixed-pattern operand pair.
    drive("zero", 32'h0, 32'h0, 1'b0, 33'h0);
    chk_reg("zero", 33'h0);
    drive("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 33'h0_ACF1_3568);
    chk_reg("mixed", 33'h0_ACF1_3568);

    // Reset mid-stream clears on that edge only; inputs held so the next edge reloads.
    drive("midrst", 32'h0000_0011, 32'h0000_0022, 1'b1, 33'h0_0000_0034);
    rst = 1'b1;
    chk_reg("midrst_clr", 33'h0);
    chk("midrst_comb", {co, s}, 33'h0_0000_0034);
    @(negedge clk);
    rst = 1'b0;
    chk_reg("midrst_reload", 33'h0_0000_0034);

    // Randomized regression, one vector per clock period.
    for (int i = 0; i < 24; i++) begin
      rx   = $urandom;
      ry   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rexp = model(rx, ry, rc);
      drive($sformatf("rnd%0d", i), rx, ry, rc, rexp);
      chk_reg($sformatf("rnd%0d", i), rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_cla.md
Name: adder_cla

Overview:
- Parameterised carry-lookahead adder: o_s/o_c = i_a + i_b + i_c, available combinationally in the same cycle as the inputs.
- Adds a registered copy of the result (1-cycle latency) for pipelined consumers in the datapath.
- Internal structure is a two-level lookahead: 4-bit CLA groups plus a group-level carry-lookahead unit. No ripple chain across groups.

Parameters:
- BW_DATA, 32, operand/sum width; must be a multiple of BW_GRP; supported values 4..64.
- BW_GRP, 4, bits per lookahead group.

Ports:
- i_clk  input  1  clock, rising-edge active.
- i_rst  input  1  synchronous reset, active-high.
- i_a  input  BW_DATA  operand A, unsigned.
- i_b  input  BW_DATA  operand B, unsigned.
- i_c  input  1  carry-in.
- o_s  output  BW_DATA  sum, combinational.
- o_c  output  1  carry-out, combinational.
- o_s_q  output  BW_DATA  registered sum.
- o_c_q  output  1  registered carry-out.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Arithmetic: {o_c, o_s} = i_a + i_b + i_c, computed at full precision of BW_DATA+1 bits; modulo wrap into o_s with overflow in o_c.
- Combinational path:
  - o_s/o_c have zero clock latency.
  - They must settle within 1 ns of an input change in behavioural simulation; no delays on combinational paths.
  - They are independent of i_clk and i_rst, so reset does not force them.
- Bit level: p[k] = a[k]^b[k], g[k] = a[k]&b[k], s[k] = p[k]^c[k].
- Group level, per BW_GRP group:
  - Carries c[k+1] = g[k] | p[k]&c[k], fully expanded (lookahead form) within the group.
  - Group propagate PG = AND of p.
  - Group generate GG = expanded generate of the group.
- Second level: group carries C[j+1] = GG[j] | PG[j]&C[j], fully expanded from C[0]=i_c.
- Carry-out: o_c = C[BW_DATA/BW_GRP].
- Registered path:
  - On each rising i_clk edge, o_s_q <= o_s and o_c_q <= o_c (1-cycle latency).
  - If i_rst=1 at the edge, o_s_q=0 and o_c_q=0; reset has priority over the capture.
  - Reset asserted mid-stream clears both registers on that edge only. The first result after deassert appears on the edge following deassert.
- Unknown inputs (X/Z) propagate X to the outputs; no special handling.
- No handshake; inputs are sampled every cycle.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_a=5, i_b=7 -> o_s_q=0, o_c_q=0; o_s=12, o_c=0 throughout.
- Full carry ripple: i_a=0xFFFFFFFF, i_b=0, i_c=1 -> o_s=0, o_c=1 within 1 ns. This exercises propagate through all 8 groups.
- Max sum: i_a=0xFFFFFFFF, i_b=0xFFFFFFFF, i_c=1 -> o_s=0xFFFFFFFF, o_c=1. Next edge: o_s_q=0xFFFFFFFF, o_c_q=1.
- Group boundary: i_a=0x0000000F, i_b=0x00000001, i_c=0 -> o_s=0x00000010, o_c=0. Also i_a=0x7FFFFFFF, i_b=1 -> o_s=0x80000000, o_c=0.
- Zero/identity: all inputs 0 -> o_s=0, o_c=0. Then i_a=0x12345678, i_b=0x9ABCDEF0, i_c=0 -> o_s=0xACF13568, o_c=0.
- Random regression: 10+ vectors applied one per 10 ns. Check o_s/o_c 1 ns after each apply and o_s_q/o_c_q one cycle later against a behavioural a+b+c model; report mismatch count, which must be 0.
